// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - execute-stage multiply/divide unit with HI/LO ownership
//
// Fixed-latency multi-cycle MDU for the pipelined MIPS core. The 64-bit result
// is computed at the Start edge, parked in a pending register, and committed to
// {HI,LO} when the busy down-counter expires.
//
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 5-8).
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   MDUOpE    in   [3:0] op in E: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5-8 MADD family
//   MTHILOE   in   [1:0] bit1 write HI, bit0 write LO from A (2'b11 = none)
//   MFHILOE   in   [1:0] 2'b10 read HI, 2'b01 read LO
//   A, B      in   [31:0] forwarded rs / rt operands
//   ExcFlush  in   kill the instruction in E this cycle
//   MDUUseD   in   instruction in D uses the MDU
//   Start     out  operation accepted this cycle (combinational)
//   Busy      out  operation in flight (registered)
//   StallMDU  out  stall request to the hazard unit
//   HI, LO    out  [31:0] architectural HI/LO registers
//   MDUOutE   out  [31:0] MFHI/MFLO result

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOpE,
  input  logic [1:0]  MTHILOE,
  input  logic [1:0]  MFHILOE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ExcFlush,
  input  logic        MDUUseD,
  output logic        Start,
  output logic        Busy,
  output logic        StallMDU,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOutE
);

  localparam int CW = 16;

  logic [CW-1:0] cnt;
  logic [63:0]   pending;
  logic [63:0]   result;
  logic [63:0]   hilo;
  logic [63:0]   ext_a;
  logic [63:0]   ext_b;
  logic [63:0]   product;
  logic          op_valid;
  logic          op_signed;
  logic          op_div;
  logic          op_acc;
  logic          op_sub;
  logic          neg_a;
  logic          neg_b;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quot;
  logic [31:0]   rem;
  logic          mt_we;

  assign hilo = {HI, LO};

  always_comb begin
    op_valid  = 1'b0;
    op_signed = 1'b0;
    op_div    = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (MDUOpE)
      4'd1: begin op_valid = 1'b1; op_signed = 1'b1; end
      4'd2: begin op_valid = 1'b1; end
      4'd3: begin op_valid = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
      4'd4: begin op_valid = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
      4'd5: begin op_valid = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      4'd6: begin op_valid = 1'b1; op_acc = 1'b1; end
      4'd7: begin op_valid = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      4'd8: begin op_valid = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`else
      4'd5, 4'd6, 4'd7, 4'd8: op_valid = 1'b0;
`endif
      default: op_valid = 1'b0;
    endcase
  end

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned multiplication.
  assign ext_a   = op_signed ? {{32{A[31]}}, A} : {32'd0, A};
  assign ext_b   = op_signed ? {{32{B[31]}}, B} : {32'd0, B};
  assign product = ext_a * ext_b;

  // Signed divide via magnitudes: truncation toward zero, remainder follows the
  // dividend. 0x80000000 / -1 falls out naturally as quotient 0x80000000, rem 0.
  assign neg_a = op_signed & A[31];
  assign neg_b = op_signed & B[31];
  assign abs_a = neg_a ? (~A + 32'd1) : A;
  assign abs_b = neg_b ? (~B + 32'd1) : B;
  assign uq    = (abs_b != 32'd0) ? (abs_a / abs_b) : 32'd0;
  assign ur    = (abs_b != 32'd0) ? (abs_a % abs_b) : 32'd0;
  assign quot  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign rem   = neg_a ? (~ur + 32'd1) : ur;

  always_comb begin
    result = product;
    if (op_div) begin
      result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {rem, quot};
    end else if (op_acc) begin
      result = op_sub ? (hilo - product) : (hilo + product);
    end
  end

  assign Start    = op_valid & ~Busy & ~ExcFlush & reset;
  assign mt_we    = ((MTHILOE == 2'b10) || (MTHILOE == 2'b01)) & ~ExcFlush;
  assign StallMDU = MDUUseD & (Busy | Start);

  always_comb begin
    case (MFHILOE)
      2'b10:   MDUOutE = HI;
      2'b01:   MDUOutE = LO;
      default: MDUOutE = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      Busy    <= 1'b0;
      pending <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      if (Start) begin
        pending <= result;
        cnt     <= op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        Busy    <= 1'b1;
      end else if (mt_we) begin
        // An MT write aborts any in-flight op so the pending result never lands.
        cnt     <= '0;
        Busy    <= 1'b0;
        pending <= '0;
      end else if (cnt != '0) begin
        cnt  <= cnt - CW'(1);
        Busy <= (cnt != CW'(1));
        if (cnt == CW'(1)) begin
          HI <= pending[63:32];
          LO <= pending[31:0];
        end
      end
      if (mt_we) begin
        if (MTHILOE[1]) HI <= A;
        else            LO <= A;
      end
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Execute-stage multiply/divide unit for the pipelined MIPS core. It consumes the MDU control fields that the ID/EX pipeline register delivers (`MDUOpE`, `MTHILOE`, `MFHILOE`) together with the forwarded operands. It runs a fixed-latency multi-cycle operation, owns the HI/LO registers, and returns the MFHI/MFLO result to the E stage. It also produces the stall request that the hazard unit uses to freeze IF/ID and flush ID/EX while an MDU-dependent instruction waits in D.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for multiply operations (≥1).
- `DIV_CYCLES`, default 10: busy cycles for divide operations (≥1).

- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `MDUOpE` input 4: operation in E. 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU. Any other value is none.
- `MTHILOE` input 2: bit1 write HI, bit0 write LO, both from `A`. 2'b11 is treated as none.
- `MFHILOE` input 2: 2'b10 read HI, 2'b01 read LO, else read nothing.
- `A` input 32: forwarded rs operand.
- `B` input 32: forwarded rt operand.
- `ExcFlush` input 1: the instruction in E is killed this cycle (exception or ERET).
- `MDUUseD` input 1: the instruction in D is an MDU op, MTHI/MTLO or MFHI/MFLO.
- `Start` output 1: an operation is accepted this cycle.
- `Busy` output 1: an operation is in flight.
- `StallMDU` output 1: stall request to the hazard unit.
- `HI` output 32: HI register.
- `LO` output 32: LO register.
- `MDUOutE` output 32: MFHI/MFLO result.

## Operation
- `Start` = valid op (1–4, plus 5–8 when configured) & !`Busy` & !`ExcFlush` & `reset`. It is combinational.
- On a `Start` edge:
  - The 64-bit result is computed from `A`, `B` and the current {HI,LO} and held in internal pending registers.
  - The down-counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- `Busy` = (counter != 0), driven from a register.
- The counter decrements every cycle while nonzero.
- On the edge where the counter goes from 1 to 0, {HI,LO} ← pending result. This is the only commit point.
- Multiply results:
  - MULT: signed 32×32, {HI,LO} = product.
  - MULTU: unsigned 32×32, {HI,LO} = product.
- Divide results:
  - DIV and DIVU give LO = quotient and HI = remainder.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Divisor zero (DIV and DIVU): LO = 32'hFFFF_FFFF, HI = `A`.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- MTHI/MTLO:
  - When `MTHILOE` is 10 or 01 and `ExcFlush` is 0, the selected register ← `A` at the edge.
  - If `Busy` is 1 at that edge, the write still applies, the counter clears, and the pending result is discarded.
- `MDUOutE`: HI when `MFHILOE` = 10, LO when 01, else 0. It is combinational from the registers; there is no bypass of the pending result.
- `ExcFlush` suppresses `Start` and MT writes in the same cycle. It does not cancel an operation already in flight.
- A valid `MDUOpE` while `Busy` is 1 is ignored; the hazard unit prevents this case.
- `StallMDU` = `MDUUseD` & (`Busy` | `Start`).

## Timing
- Reset (`reset` = 0) takes effect asynchronously:
  - HI = 0, LO = 0, counter = 0, pending result = 0.
  - `Busy` = 0, `Start` = 0, `StallMDU` = 0, `MDUOutE` = 0.
- Reset asserted mid-operation aborts it; no later commit occurs.
- Latency, with the `Start` cycle as cycle 0:
  - `Busy` is high in cycles 1..N.
  - New HI/LO are visible from cycle N+1.
  - N = `MULT_CYCLES` or `DIV_CYCLES`.
- An MFHI in D stalls through cycle N and reads the new value in E in cycle N+1 or later.
- A back-to-back op is accepted in cycle N+1. Accepting in the cycle where `Busy` falls is not allowed.

## Configuration
- `MDU_MADD_EN` defined:
  - Ops 5–8 are valid.
  - {HI,LO} ← {HI,LO} ± product, mod 2^64, using the {HI,LO} value at the `Start` edge.
  - MADD/MSUB treat the operands as signed; MADDU/MSUBU treat them as unsigned.
  - Latency is `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: ops 5–8 are treated as none (no `Start`, no state change).

## Test plan
- Reset: hold `reset` = 0 mid-DIV (counter = 3), then release. Required: HI = LO = 0 and `Busy` = 0 immediately, and HI/LO stay 0 afterwards.
- Multiply:
  - MULT with A = 32'hFFFF_FFFE, B = 3. Required: `Busy` high 5 cycles, then HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFA.
  - MULTU with the same operands. Required: HI = 2, LO = 32'hFFFF_FFFA.
- Divide:
  - DIV with A = 32'hFFFF_FFF9, B = 2. Required: after 10 cycles LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF.
  - DIVU with A = 7, B = 0. Required: LO = 32'hFFFF_FFFF, HI = 7.
- Stall handshake: MULT starts with `MDUUseD` = 1 and an MFHI in D. Required: `StallMDU` high for 6 cycles (the start cycle plus 5 busy cycles), then drops; the next cycle `MDUOutE` equals the new HI.
- Flush:
  - `ExcFlush` = 1 with MULT in E. Required: `Start` = 0, `Busy` stays 0.
  - `ExcFlush` = 1 with `MTHILOE` = 10, A = 5. Required: HI unchanged.
  - `ExcFlush` = 1 during a busy operation. Required: the operation still commits.
- `MDU_MADD_EN` defined: start from HI = 0, LO = 32'hFFFF_FFFF and issue MADDU with A = 1, B = 1. Required: HI = 1, LO = 0. With the macro undefined, the same stimulus leaves HI/LO unchanged and `Start` = 0.
